// File: rtl/instr_fetch_buffer.sv
// ============================================================================
// instr_fetch_buffer
// ----------------------------------------------------------------------------
// Purpose:
//   Fetches 32-bit instruction words from instruction memory, buffers them in
//   an in-order FIFO and hands one {instruction, pc} pair per handshake to the
//   decoder. A redirect (taken branch/jump) flushes the FIFO and marks every
//   read still in flight as wrong-path so its response is dropped on arrival.
//
// Optional feature (compile-time macro IFB_BYPASS_EN):
//   When defined, a response that arrives while the FIFO is empty, nothing
//   is being discarded and no redirect is active is shown to the decoder in
//   the same cycle. It is written into the FIFO only if the decoder does not
//   take it immediately. When undefined, the decoder only ever sees FIFO
//   registers (one cycle of latency from response to instr_valid).
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   imem_req_valid/ready, imem_addr  read request channel (word-aligned address)
//   imem_rsp_valid, imem_rsp_data    in-order read responses, no backpressure
//   instr_valid/ready, instruction,  decoder-side handshake with the PC of the
//   instr_pc                         presented instruction
//   redirect_valid, redirect_pc      one-cycle redirect pulse and target
// ============================================================================
module instr_fetch_buffer #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instruction,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ---------------- state ----------------
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_discard;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [31:0]     r_mem_data [DEPTH];
    logic [XLEN-1:0] r_mem_pc   [DEPTH];
    logic            r_req_valid;
    logic            r_instr_valid;
    logic [31:0]     r_instruction;
    logic [XLEN-1:0] r_instr_pc;

    // ---------------- combinational ----------------
    logic            w_req_hs;
    logic            w_rsp_keep;
    logic            w_fifo_pop;
    logic            w_bypass;
    logic            w_push;
    logic [XLEN-1:0] w_redirect_pc;
    logic [CW-1:0]   w_outst_next;
    logic [CW-1:0]   w_count_next;
    logic [CW-1:0]   w_discard_next;
    logic [PW-1:0]   w_rd_next;
    logic [PW-1:0]   w_wr_next;
    logic [XLEN-1:0] w_fetch_pc_next;
    logic [XLEN-1:0] w_rsp_pc_next;
    logic [CW:0]     w_occ_next;
    logic [31:0]     w_head_data;
    logic [XLEN-1:0] w_head_pc;
    logic            w_unused_pc_lsbs;

    // Low target bits are architecturally ignored (word-aligned fetch).
    assign w_unused_pc_lsbs = ^redirect_pc[1:0];
    assign w_redirect_pc    = {redirect_pc[XLEN-1:2], 2'b00};

    assign w_req_hs   = r_req_valid & imem_req_ready;
    // A response is kept only when it is not owed to an earlier redirect and
    // no redirect is flushing the pipeline this very cycle.
    assign w_rsp_keep = imem_rsp_valid & (r_discard == {CW{1'b0}}) & ~redirect_valid;
    assign w_fifo_pop = r_instr_valid & instr_ready;

`ifdef IFB_BYPASS_EN
    assign w_bypass    = w_rsp_keep & (r_count == {CW{1'b0}});
    assign w_push      = w_rsp_keep & ~(w_bypass & instr_ready);
    assign instr_valid = r_instr_valid | w_bypass;
    assign instruction = w_bypass ? imem_rsp_data : r_instruction;
    assign instr_pc    = w_bypass ? r_rsp_pc : r_instr_pc;
`else
    assign w_bypass    = 1'b0;
    assign w_push      = w_rsp_keep;
    assign instr_valid = r_instr_valid;
    assign instruction = r_instruction;
    assign instr_pc    = r_instr_pc;
`endif

    assign imem_req_valid = r_req_valid;
    assign imem_addr      = r_fetch_pc;

    // Next-state computation for counters, pointers, PCs and the FIFO head.
    always_comb begin
        w_outst_next = r_outst + CW'(w_req_hs) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            w_count_next    = {CW{1'b0}};
            w_rd_next       = {PW{1'b0}};
            w_wr_next       = {PW{1'b0}};
            w_discard_next  = w_outst_next;
            w_fetch_pc_next = w_redirect_pc;
            w_rsp_pc_next   = w_redirect_pc;
        end else begin
            w_count_next = r_count + CW'(w_push) - CW'(w_fifo_pop);
            w_rd_next    = r_rd_ptr + PW'(w_fifo_pop);
            w_wr_next    = r_wr_ptr + PW'(w_push);
            if (imem_rsp_valid && (r_discard != {CW{1'b0}})) begin
                w_discard_next = r_discard - CW'(1'b1);
            end else begin
                w_discard_next = r_discard;
            end
            if (w_req_hs) begin
                w_fetch_pc_next = r_fetch_pc + XLEN'(3'd4);
            end else begin
                w_fetch_pc_next = r_fetch_pc;
            end
            // rsp_pc advances for every kept response, bypassed or buffered.
            if (w_rsp_keep) begin
                w_rsp_pc_next = r_rsp_pc + XLEN'(3'd4);
            end else begin
                w_rsp_pc_next = r_rsp_pc;
            end
        end

        w_occ_next = {1'b0, w_count_next} + {1'b0, w_outst_next};

        // The slot being written this cycle becomes the head when the FIFO
        // was (or is becoming) empty, so forward the incoming word.
        if (w_push && (r_wr_ptr == w_rd_next)) begin
            w_head_data = imem_rsp_data;
            w_head_pc   = r_rsp_pc;
        end else begin
            w_head_data = r_mem_data[w_rd_next];
            w_head_pc   = r_mem_pc[w_rd_next];
        end
    end

    // State registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_count       <= {CW{1'b0}};
            r_outst       <= {CW{1'b0}};
            r_discard     <= {CW{1'b0}};
            r_wr_ptr      <= {PW{1'b0}};
            r_rd_ptr      <= {PW{1'b0}};
            r_req_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instruction <= 32'h0000_0000;
            r_instr_pc    <= {XLEN{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_data[i] <= 32'h0000_0000;
                r_mem_pc[i]   <= {XLEN{1'b0}};
            end
        end else begin
            r_fetch_pc    <= w_fetch_pc_next;
            r_rsp_pc      <= w_rsp_pc_next;
            r_count       <= w_count_next;
            r_outst       <= w_outst_next;
            r_discard     <= w_discard_next;
            r_wr_ptr      <= w_wr_next;
            r_rd_ptr      <= w_rd_next;
            // Credit rule evaluated on the post-edge state, so the request
            // line is a clean register that holds until its handshake.
            r_req_valid   <= (w_occ_next < (CW + 1)'(DEPTH));
            r_instr_valid <= (w_count_next != {CW{1'b0}});
            r_instruction <= w_head_data;
            r_instr_pc    <= w_head_pc;
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= imem_rsp_data;
                r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
            end else begin
                r_mem_data[r_wr_ptr] <= r_mem_data[r_wr_ptr];
                r_mem_pc[r_wr_ptr]   <= r_mem_pc[r_wr_ptr];
            end
        end
    end

    instr_fetch_buffer_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .count          (r_count),
        .outst          (r_outst),
        .imem_rsp_valid (imem_rsp_valid)
    );

endmodule

// ============================================================================
// instr_fetch_buffer_chk
// ----------------------------------------------------------------------------
// Purpose: runtime invariants of the fetch buffer (credit bound, no orphan
// responses). Observes only; drives nothing.
// Ports: clk, rst_n, count/outst (internal counters), imem_rsp_valid.
// ============================================================================
module instr_fetch_buffer_chk #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] count,
    input logic [CW-1:0] outst,
    input logic          imem_rsp_valid
);

    // Buffered plus in-flight words never exceed the FIFO capacity.
    a_credit_bound : assert property (@(posedge clk) disable iff (!rst_n)
        (({1'b0, count} + {1'b0, outst}) <= (CW + 1)'(DEPTH)));

    // Memory must never answer a read that was never issued.
    a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst_n)
        (imem_rsp_valid |-> (outst != {CW{1'b0}})));

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    instr_fetch_buffer #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Reference model: reads in flight (with path tag and due cycle) and the
    // words the decoder is still owed, in program order.
    typedef struct { logic [31:0] addr; int tag; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;

    req_t        mq[$];
    ins_t        bq[$];
    logic [31:0] hs_log[$];
    ins_t        pop_log[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    int          pct_ready = 100;
    int          pct_iready = 100;
    int          pct_redir = 0;
    logic [31:0] model_fetch = RESET_PC;
    bit          force_redir = 1'b0;
    logic [31:0] force_tgt = 32'h0;
    bit          last_hs, last_rsp;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0000: memf = 32'h0031_0233;
            32'h0000_0004: memf = 32'h0031_1333;
            32'h0000_0008: memf = 32'h00e2_0613;
            default:       memf = {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // One clock cycle: drive inputs at negedge, check outputs, advance model.
    task automatic step();
        bit          redir, rsp, keep, hs, pop, exp_iv, exp_rv;
        logic [31:0] tgt;
        @(negedge clk);
        imem_req_ready = ($urandom_range(99) < pct_ready);
        instr_ready    = ($urandom_range(99) < pct_iready);
        redir          = force_redir || ($urandom_range(99) < pct_redir);
        tgt            = force_redir ? force_tgt : $urandom();
        force_redir    = 1'b0;
        redirect_valid = redir;
        redirect_pc    = redir ? tgt : $urandom();
        rsp            = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memf(mq[0].addr) : $urandom();
        keep           = rsp && (mq[0].tag == epoch) && !redir;
        #1;
        exp_rv = (bq.size() + mq.size()) < DEPTH;
        n_checks++;
        if (imem_req_valid !== exp_rv) begin
            n_errors++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
        end
`ifdef IFB_BYPASS_EN
        exp_iv = (bq.size() > 0) || keep;
`else
        exp_iv = (bq.size() > 0);
`endif
        n_checks++;
        if (instr_valid !== exp_iv) begin
            n_errors++;
            $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, exp_iv);
        end
        hs = (imem_req_valid === 1'b1) && imem_req_ready;
        if (hs) begin
            n_checks++;
            if (imem_addr !== model_fetch) begin
                n_errors++;
                $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, model_fetch);
            end
            hs_log.push_back(imem_addr);
        end
        if (keep) bq.push_back('{pc: mq[0].addr, data: memf(mq[0].addr)});
        pop = (instr_valid === 1'b1) && instr_ready;
        if (pop) begin
            n_checks++;
            if (bq.size() == 0) begin
                n_errors++;
                $display("FAIL pop_unexpected cyc=%0d got pc=%h exp=no instruction", cyc, instr_pc);
            end else if (instruction !== bq[0].data || instr_pc !== bq[0].pc) begin
                n_errors++;
                $display("FAIL pop_word cyc=%0d got=%h@%h exp=%h@%h", cyc, instruction, instr_pc,
                         bq[0].data, bq[0].pc);
                void'(bq.pop_front());
            end else begin
                void'(bq.pop_front());
            end
            pop_log.push_back('{pc: instr_pc, data: instruction});
        end
        if (rsp) void'(mq.pop_front());
        if (hs) begin
            mq.push_back('{addr: model_fetch, tag: epoch, due: cyc + lat});
            model_fetch = model_fetch + 32'd4;
        end
        if (redir) begin
            epoch++;
            bq.delete();
            model_fetch = {tgt[31:2], 2'b00};
            hs_log.delete();
            pop_log.delete();
        end
        n_checks++;
        if ((bq.size() + mq.size()) > DEPTH) begin
            n_errors++;
            $display("FAIL credit_bound cyc=%0d got=%0d exp<=%0d", cyc, bq.size() + mq.size(), DEPTH);
        end
        last_hs  = hs;
        last_rsp = rsp;
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        mq.delete();
        bq.delete();
        hs_log.delete();
        pop_log.delete();
        model_fetch = RESET_PC;
        epoch++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h0 || instr_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs got rv=%b iv=%b ins=%h pc=%h exp=0,0,0,0",
                     imem_req_valid, instr_valid, instruction, instr_pc);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        lat = 1; pct_ready = 100; pct_iready = 100; pct_redir = 0;
        repeat (10) step();
        n_checks++;
        if (hs_log.size() < 3 || hs_log[0] !== 32'h0 || hs_log[1] !== 32'h4 || hs_log[2] !== 32'h8) begin
            n_errors++;
            $display("FAIL basic_addr got n=%0d a0=%h a1=%h a2=%h exp 0,4,8",
                     hs_log.size(), hs_log[0], hs_log[1], hs_log[2]);
        end
        n_checks++;
        if (pop_log.size() < 3 || pop_log[0].data !== 32'h0031_0233 || pop_log[1].data !== 32'h0031_1333 ||
            pop_log[2].data !== 32'h00e2_0613 || pop_log[2].pc !== 32'h8) begin
            n_errors++;
            $display("FAIL basic_words got n=%0d w0=%h w1=%h w2=%h pc2=%h exp 00310233,00311333,00e20613 pc 8",
                     pop_log.size(), pop_log[0].data, pop_log[1].data, pop_log[2].data, pop_log[2].pc);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        lat = 1; pct_ready = 100; pct_iready = 0; pct_redir = 0;
        repeat (12) step();
        n_checks++;
        if (hs_log.size() != DEPTH || imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_full got hs=%0d rv=%b exp hs=4 rv=0", hs_log.size(), imem_req_valid);
        end
        pct_iready = 100;
        step();
        pct_iready = 0;
        repeat (6) step();
        n_checks++;
        if (hs_log.size() != DEPTH + 1) begin
            n_errors++;
            $display("FAIL bp_one_credit got hs=%0d exp=5", hs_log.size());
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        lat = 3; pct_ready = 100; pct_iready = 100; pct_redir = 0;
        repeat (5) step();
        force_redir = 1'b1; force_tgt = 32'h0000_0103;
        step();
        repeat (10) step();
        n_checks++;
        if (hs_log.size() < 1 || hs_log[0] !== 32'h100) begin
            n_errors++;
            $display("FAIL redir_addr got n=%0d a=%h exp=00000100", hs_log.size(), hs_log[0]);
        end
        n_checks++;
        if (pop_log.size() < 1 || pop_log[0].pc !== 32'h100) begin
            n_errors++;
            $display("FAIL redir_pc got n=%0d pc=%h exp=00000100", pop_log.size(), pop_log[0].pc);
        end
    endtask

    task automatic test_redirect_same_cycle();
        apply_reset();
        lat = 1; pct_ready = 100; pct_iready = 100; pct_redir = 0;
        repeat (6) step();
        force_redir = 1'b1; force_tgt = 32'h0000_0040;
        step();
        n_checks++;
        if (!(last_hs && last_rsp)) begin
            n_errors++;
            $display("FAIL same_cycle_setup got hs=%b rsp=%b exp=1,1", last_hs, last_rsp);
        end
        repeat (8) step();
        n_checks++;
        if (pop_log.size() < 1 || pop_log[0].pc !== 32'h40) begin
            n_errors++;
            $display("FAIL same_cycle_pc got n=%0d pc=%h exp=00000040", pop_log.size(), pop_log[0].pc);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        lat = 1; pct_ready = 100; pct_iready = 100; pct_redir = 0;
        repeat (3) step();
        force_redir = 1'b1; force_tgt = 32'hFFFF_FFFA;
        step();
        repeat (8) step();
        n_checks++;
        if (hs_log.size() < 3 || hs_log[1] !== 32'hFFFF_FFFC || hs_log[2] !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_addr got n=%0d a1=%h a2=%h exp fffffffc,00000000", hs_log.size(), hs_log[1], hs_log[2]);
        end
        n_checks++;
        if (pop_log.size() < 3 || pop_log[2].pc !== 32'h0 || pop_log[2].data !== 32'h0031_0233) begin
            n_errors++;
            $display("FAIL wrap_pop got n=%0d pc=%h d=%h exp 00000000,00310233", pop_log.size(), pop_log[2].pc,
                     pop_log[2].data);
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        lat = 1; pct_ready = 100; pct_iready = 0; pct_redir = 0;
        for (int i = 0; i < 20 && bq.size() < 3; i++) step();
        n_checks++;
        if (bq.size() < 3) begin
            n_errors++;
            $display("FAIL midrst_fill got=%0d exp>=3", bq.size());
        end
        rst_n = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || instr_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL midrst_outputs got iv=%b rv=%b pc=%h exp 0,0,0", instr_valid, imem_req_valid, instr_pc);
        end
        apply_reset();
        pct_iready = 100;
        repeat (6) step();
        n_checks++;
        if (hs_log.size() < 1 || hs_log[0] !== RESET_PC || pop_log.size() < 1 ||
            pop_log[0].data !== 32'h0031_0233) begin
            n_errors++;
            $display("FAIL midrst_restart got a=%h d=%h exp %h,00310233", hs_log[0], pop_log[0].data, RESET_PC);
        end
    endtask

    task automatic test_random();
        apply_reset();
        pct_redir = 4;
        for (int seg = 0; seg < 4; seg++) begin
            // Latency only changes while nothing is in flight, keeping responses ordered.
            pct_ready = 100; pct_iready = 100;
            lat = $urandom_range(4, 1);
            pct_ready  = $urandom_range(100, 30);
            pct_iready = $urandom_range(100, 20);
            repeat (500) step();
            pct_ready = 0; pct_redir = 0;
            repeat (12) step();
            pct_redir = 4;
        end
        pct_redir = 0;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
